// File: rtl/iram_boot_loader.sv
// Boot loader for the 32-bit instruction RAM.
// Parses a framed byte stream (sync, 16-bit length, big-endian words, XOR checksum).
// Writes each word to IRAM from address 0 upward, and keeps the CPU stalled
// until a complete image with a valid checksum has been loaded.
module iram_boot_loader #(
  parameter int         ADDR_WIDTH  = 10,
  parameter int         MAX_WORDS   = 129,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam int                  TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]         MAX_LEN = 16'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [7:0]              csum_q, csum_d;
  logic [1:0]              bidx_q, bidx_d;
  logic [23:0]             asm_q, asm_d;      // first three bytes of the word in flight
  logic [TO_W-1:0]         tcnt_q, tcnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]             wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   wc_q, wc_d;

  logic                    accept;
  logic                    timed_state;
  logic [15:0]             len_full;
  logic [15:0]             wc_next16;

  assign rx_ready    = state_q inside {S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
  assign timed_state = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
  assign accept      = rx_valid & rx_ready;
  assign len_full    = {len_q[15:8], rx_data};
  assign wc_next16   = 16'(wc_q) + 16'd1;

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = wc_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign load_done  = (state_q == S_DONE);
  assign load_error = (state_q == S_ERROR);

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      csum_q    <= '0;
      bidx_q    <= '0;
      asm_q     <= '0;
      tcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wc_q      <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      bidx_q    <= bidx_d;
      asm_q     <= asm_d;
      tcnt_q    <= tcnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wc_q      <= wc_d;
    end
  end

  // Frame parser: next state, word assembly, IRAM write request and inter-byte timeout
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    csum_d    = csum_q;
    bidx_d    = bidx_q;
    asm_d     = asm_q;
    tcnt_d    = tcnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wc_d      = wc_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_SYNC;
          wc_d    = '0;
          csum_d  = '0;
          bidx_d  = '0;
          tcnt_d  = '0;
        end
      end
      S_SYNC: begin
        if (accept && (rx_data == SYNC_BYTE)) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {rx_data, 8'h00};
          csum_d  = csum_q ^ rx_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d  = len_full;
          csum_d = csum_q ^ rx_data;
          if ((len_full == 16'd0) || (len_full > MAX_LEN)) state_d = S_ERROR;
          else                                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          bidx_d = bidx_q + 2'd1;
          asm_d  = {asm_q[15:0], rx_data};
          // Fourth byte completes a word: write it next cycle at the pre-increment count
          if (bidx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wc_q;
            wr_data_d = {asm_q, rx_data};
            wc_d      = wc_q + ONE_A;
            if (wc_next16 == len_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // Idle cycles between bytes are only bounded once the sync byte has been seen
    if (timed_state) begin
      if (accept) begin
        tcnt_d = '0;
      end else if (tcnt_q == TO_LAST) begin
        tcnt_d  = '0;
        state_d = S_ERROR;
      end else begin
        tcnt_d = tcnt_q + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iram_boot_loader.sv
// Self-checking bench for iram_boot_loader: directed frames plus randomized frames,
// checked every cycle against a byte-list reference model.
module tb_iram_boot_loader;

  localparam int         AW = 10;
  localparam int         MW = 129;
  localparam int         TO = 1000;
  localparam logic [7:0] SB = 8'hA5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW-1:0] word_count;

  iram_boot_loader #(
    .ADDR_WIDTH(AW), .MAX_WORDS(MW), .SYNC_BYTE(SB), .TIMEOUT_CYC(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame as a list of accepted bytes) ----------------
  logic          e_ready = 1'b0;
  logic          e_wr_en = 1'b0;
  logic [AW-1:0] e_wr_addr = '0;
  logic [31:0]   e_wr_data = '0;
  logic          e_done = 1'b0;
  logic          e_err = 1'b0;
  logic [AW-1:0] e_wc = '0;
  bit            m_active = 1'b0;
  bit            m_synced = 1'b0;
  int            m_idle = 0;
  int            m_len = 0;
  logic [7:0]    fr[$];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_ready = 0; e_wr_en = 0; e_wr_addr = '0; e_wr_data = '0;
      e_done = 0; e_err = 0; e_wc = '0;
      m_active = 0; m_synced = 0; m_idle = 0; fr.delete();
    end else begin
      bit acc;
      int p;
      logic [7:0] x;
      acc = e_ready && rx_valid;
      e_wr_en = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_synced = 0; m_idle = 0; fr.delete();
          e_done = 0; e_err = 0; e_wc = '0;
        end
      end else if (!m_synced) begin
        if (acc && rx_data == SB) m_synced = 1;
      end else if (acc) begin
        m_idle = 0;
        fr.push_back(rx_data);
        p = fr.size() - 1;
        if (p == 1) begin
          m_len = {fr[0], fr[1]};
          if (m_len == 0 || m_len > MW) begin m_active = 0; e_err = 1; end
        end else if (p >= 2 && p < 2 + 4 * m_len) begin
          if ((p - 2) % 4 == 3) begin
            e_wr_en   = 1'b1;
            e_wr_addr = AW'((p - 2) / 4);
            e_wr_data = {fr[p-3], fr[p-2], fr[p-1], fr[p]};
            e_wc      = AW'((p - 2) / 4 + 1);
          end
        end else if (p == 2 + 4 * m_len) begin
          x = 8'h00;
          for (int i = 0; i < p; i++) x = x ^ fr[i];
          m_active = 0;
          if (x == rx_data) e_done = 1; else e_err = 1;
        end
      end else begin
        m_idle++;
        if (m_idle >= TO) begin m_active = 0; e_err = 1; end
      end
      e_ready = m_active;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    chk("rx_ready", 64'(rx_ready), 64'(e_ready));
    chk("wr_en", 64'(wr_en), 64'(e_wr_en));
    chk("wr_addr", 64'(wr_addr), 64'(e_wr_addr));
    chk("wr_data", 64'(wr_data), 64'(e_wr_data));
    chk("cpu_hold", 64'(cpu_hold), 64'(!e_done));
    chk("load_done", 64'(load_done), 64'(e_done));
    chk("load_error", 64'(load_error), 64'(e_err));
    chk("word_count", 64'(word_count), 64'(e_wc));
  end

  // Observed IRAM contents and write count, for the literal checks
  logic [31:0] mem_obs[0:1023];
  int          wr_seen = 0;
  always @(posedge clock) begin
    if (wr_en) begin
      mem_obs[wr_addr] <= wr_data;
      wr_seen <= wr_seen + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0]  gq[$];
  logic [31:0] exp_words[0:MW-1];

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic play(input int maxgap, input bit rnd_start);
    foreach (gq[i]) begin
      rx_data  = gq[i];
      rx_valid = 1'b1;
      if (rnd_start && $urandom_range(0, 7) == 0) start = 1'b1;
      @(posedge clock); #2;
      rx_valid = 1'b0;
      start    = 1'b0;
      rx_data  = 8'($urandom);
      wait_cycles($urandom_range(0, maxgap));
    end
  endtask

  task automatic build_frame(input int len, input bit corrupt);
    logic [7:0] x;
    logic [31:0] w;
    gq.delete();
    gq.push_back(SB);
    gq.push_back(8'(len >> 8));
    gq.push_back(8'(len));
    x = 8'(len >> 8) ^ 8'(len);
    for (int k = 0; k < len; k++) begin
      w = $urandom;
      if (k < MW) exp_words[k] = w;
      for (int b = 3; b >= 0; b--) begin
        gq.push_back(w[b*8 +: 8]);
        x = x ^ w[b*8 +: 8];
      end
    end
    gq.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
  endtask

  int w0;

  initial begin
    // Reset state
    wait_cycles(2);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_ready", 64'(rx_ready), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_wcnt", 64'(word_count), 64'd0);
    reset = 1'b1;
    wait_cycles(2);

    // Two-word frame; XOR of 00 02 6C 00 00 00 54 00 00 50 is 0x6A
    w0 = wr_seen;
    pulse_start();
    gq = '{8'hA5, 8'h00, 8'h02, 8'h6C, 8'h00, 8'h00, 8'h00, 8'h54, 8'h00, 8'h00, 8'h50, 8'h6A};
    play(0, 0);
    wait_cycles(1);
    chk("t1_done", 64'(load_done), 64'd1);
    chk("t1_hold", 64'(cpu_hold), 64'd0);
    chk("t1_wcnt", 64'(word_count), 64'd2);
    chk("t1_w0", 64'(mem_obs[0]), 64'h6C000000);
    chk("t1_w1", 64'(mem_obs[1]), 64'h54000050);
    chk("t1_nwr", 64'(wr_seen - w0), 64'd2);

    // Same frame with a wrong checksum: both words still written, then error
    w0 = wr_seen;
    pulse_start();
    chk("t2_hold_after_start", 64'(cpu_hold), 64'd1);
    gq[11] = 8'h3A;
    play(1, 0);
    wait_cycles(1);
    chk("t2_err", 64'(load_error), 64'd1);
    chk("t2_hold", 64'(cpu_hold), 64'd1);
    chk("t2_nwr", 64'(wr_seen - w0), 64'd2);

    // Garbage before sync is discarded
    pulse_start();
    gq = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h02, 8'h6C, 8'h00, 8'h00, 8'h00,
           8'h54, 8'h00, 8'h00, 8'h50, 8'h6A};
    play(2, 0);
    wait_cycles(1);
    chk("t3_done", 64'(load_done), 64'd1);

    // Illegal lengths 0 and 130
    w0 = wr_seen;
    pulse_start();
    gq = '{8'hA5, 8'h00, 8'h00};
    play(0, 0);
    chk("t4a_err", 64'(load_error), 64'd1);
    pulse_start();
    gq = '{8'hA5, 8'h00, 8'h82};
    play(0, 0);
    chk("t4b_err", 64'(load_error), 64'd1);
    chk("t4_nwr", 64'(wr_seen - w0), 64'd0);

    // Inter-byte timeout mid-DATA fires on exactly the TO-th idle cycle
    pulse_start();
    gq = '{8'hA5, 8'h00, 8'h02, 8'h6C, 8'h00};
    play(0, 0);
    wait_cycles(TO - 1);
    chk("t5_err_early", 64'(load_error), 64'd0);
    wait_cycles(1);
    chk("t5_err_at", 64'(load_error), 64'd1);
    pulse_start();
    build_frame(3, 0);
    play(1, 0);
    chk("t5_retry_done", 64'(load_done), 64'd1);

    // Asynchronous reset after five payload bytes, then a full-depth image
    pulse_start();
    gq = '{8'hA5, 8'h00, 8'h02, 8'h6C, 8'h00, 8'h00, 8'h00, 8'h54};
    play(0, 0);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_ready", 64'(rx_ready), 64'd0);
    chk("t6_rst_wcnt", 64'(word_count), 64'd0);
    chk("t6_rst_waddr", 64'(wr_addr), 64'd0);
    chk("t6_rst_wdata", 64'(wr_data), 64'd0);
    chk("t6_rst_hold", 64'(cpu_hold), 64'd1);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    pulse_start();
    build_frame(MW, 0);
    play(1, 0);
    wait_cycles(1);
    chk("t6_done", 64'(load_done), 64'd1);
    chk("t6_wcnt", 64'(word_count), 64'(MW));
    chk("t6_first", 64'(mem_obs[0]), 64'(exp_words[0]));
    chk("t6_last", 64'(mem_obs[MW-1]), 64'(exp_words[MW-1]));

    // Randomized frames, including stray start pulses and illegal lengths
    for (int n = 0; n < 40; n++) begin
      int len;
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = MW + 1;
        2:       len = MW;
        default: len = $urandom_range(1, 12);
      endcase
      pulse_start();
      build_frame(len, ($urandom_range(0, 3) == 0));
      play(3, 1);
      wait_cycles(3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
